// File: rtl/acc_requant_drain_pkg.sv
// Shared defaults, FSM state type and saturation bounds for the accumulator requant/drain stage.
package acc_requant_drain_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_N_MACS  = 4;
  localparam int DEF_SHIFT_W = 4;

  function automatic int sat_max(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(2 ** (w - 1));
  endfunction

  localparam int SAT_MAX = sat_max(DEF_W);
  localparam int SAT_MIN = sat_min(DEF_W);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/acc_requant_drain_requant.sv
// Combinational round-half-up shift, optional ReLU and saturation of one accumulator value.
module acc_requant_drain_requant
  import acc_requant_drain_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int Q_MAX   = SAT_MAX,
  parameter int Q_MIN   = SAT_MIN
) (
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                      i_relu_en,
  output logic signed [W-1:0]       o_q,
  output logic                      o_sat
);

  localparam logic signed [ACC_W:0] L_MAX = (ACC_W + 1)'(Q_MAX);
  localparam logic signed [ACC_W:0] L_MIN = (ACC_W + 1)'(Q_MIN);

  // One extra bit keeps the rounding add from overflowing at the top of the range.
  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_half;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_shr;
  logic signed [ACC_W:0] w_rl;
  logic                  w_hi;
  logic                  w_lo;

  assign w_ext  = {i_acc[ACC_W-1], i_acc};
  assign w_half = (ACC_W + 1)'(1) << (i_shift - SHIFT_W'(1));
  assign w_rnd  = (i_shift == '0) ? w_ext : (w_ext + w_half);
  assign w_shr  = w_rnd >>> i_shift;
  assign w_rl   = (i_relu_en && (w_shr < 0)) ? '0 : w_shr;
  assign w_hi   = (w_rl > L_MAX);
  assign w_lo   = (w_rl < L_MIN);

  assign o_sat = w_hi | w_lo;
  assign o_q   = w_hi ? W'(L_MAX) : (w_lo ? W'(L_MIN) : w_rl[W-1:0]);

endmodule

// File: rtl/acc_requant_drain.sv
// Captures per-lane accumulator results, requantises them and streams one lane per beat.
//
// state      | meaning
// ST_IDLE    | waiting for the first lane valid of a frame
// ST_COLLECT | capturing lanes until every lane has been seen once
// ST_DRAIN   | loading and handing out requantised lanes 0..N_MACS-1
// ST_DONE    | one-cycle done pulse, then back to idle
module acc_requant_drain
  import acc_requant_drain_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_MACS  = DEF_N_MACS,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int LW      = $clog2(N_MACS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [N_MACS*ACC_W-1:0]   acc_in,
  input  logic [N_MACS-1:0]         acc_valid,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic                      relu_en,
  output logic [W-1:0]              out_data,
  output logic [LW-1:0]             out_lane,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      done,
  output logic                      busy,
  output logic [7:0]                sat_count
);

  localparam logic [LW-1:0] LAST_LANE = LW'(N_MACS - 1);

  state_t             r_state;
  logic [N_MACS-1:0]  r_mask;
  logic [ACC_W-1:0]   r_lane [N_MACS];
  logic [SHIFT_W-1:0] r_shift;
  logic               r_relu;
  logic [W-1:0]       r_out_data;
  logic [LW-1:0]      r_out_lane;
  logic               r_out_valid;
  logic               r_done;
  logic               r_busy;
  logic [7:0]         r_sat_count;

  logic [N_MACS-1:0]  w_mask_next;
  logic [LW-1:0]      w_next_idx;
  logic signed [W-1:0] w_q;
  logic               w_sat;

  assign w_mask_next = r_mask | acc_valid;
  // Before the first beat the register is empty, so the lane to load is 0.
  assign w_next_idx  = r_out_valid ? (r_out_lane + LW'(1)) : '0;

  acc_requant_drain_requant #(
    .W       (W),
    .ACC_W   (ACC_W),
    .SHIFT_W (SHIFT_W),
    .Q_MAX   (sat_max(W)),
    .Q_MIN   (sat_min(W))
  ) u_requant (
    .i_acc     (r_lane[w_next_idx]),
    .i_shift   (r_shift),
    .i_relu_en (r_relu),
    .o_q       (w_q),
    .o_sat     (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_sat_count <= '0;
      for (int i = 0; i < N_MACS; i++) r_lane[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          for (int i = 0; i < N_MACS; i++) begin
            if (acc_valid[i] && !r_mask[i]) r_lane[i] <= acc_in[i*ACC_W +: ACC_W];
          end
          r_mask <= w_mask_next;
          if (r_state == ST_IDLE && (|acc_valid)) begin
            r_shift <= shift;
            r_relu  <= relu_en;
            r_busy  <= 1'b1;
          end
          if (&w_mask_next)    r_state <= ST_DRAIN;
          else if (|acc_valid) r_state <= ST_COLLECT;
        end
        ST_DRAIN: begin
          if (r_out_valid && out_ready && (r_out_lane == LAST_LANE)) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end else if (!r_out_valid || out_ready) begin
            r_out_data  <= w_q;
            r_out_lane  <= w_next_idx;
            r_out_valid <= 1'b1;
            if (w_sat && (r_sat_count != 8'hFF)) r_sat_count <= r_sat_count + 8'd1;
          end
        end
        ST_DONE: begin
          r_mask  <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_lane  = r_out_lane;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign busy      = r_busy;
  assign sat_count = r_sat_count;

endmodule
